// File: rtl/seven_seg_chain_driver.sv
// rtl/seven_seg_chain_driver.sv - hex-to-7-segment frame serialiser for a daisy-chained 74HC595 chain
// Optional build macro LEADING_ZERO_BLANK_EN: blank zero digits above the highest nonzero digit.
module seven_seg_chain_driver #(
    parameter int NUM_DIGITS     = 2,
    parameter int CLK_DIV        = 4,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic [NUM_DIGITS-1:0]     i_dp,
    input  logic                      i_load,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_data_val,
    output logic                      o_data_clock,
    output logic                      o_latch_shifted_value
);

    localparam int BITS  = 8 * NUM_DIGITS;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(BITS + 1);

    // Encoding chosen so SHCP and STCP are each a single state flop, free of decode glitches.
    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_SETUP = 3'b001;
    localparam logic [2:0] ST_HIGH  = 3'b011;
    localparam logic [2:0] ST_LATCH = 3'b100;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [BITS-1:0]  shift_q, shift_d;
    logic             done_q, done_d;
    logic [BITS-1:0]  frame_d;
    logic [7:0]       seg_byte;
    logic             div_last;
`ifdef LEADING_ZERO_BLANK_EN
    logic             seen_nz;
`endif

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    // Walk from the top digit down so the blanking flag sees every higher digit first.
    always_comb begin
        frame_d  = '0;
        seg_byte = '0;
`ifdef LEADING_ZERO_BLANK_EN
        seen_nz  = 1'b0;
`endif
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seg_byte = {i_dp[k], hex_to_seg(i_value[4*k +: 4])};
`ifdef LEADING_ZERO_BLANK_EN
            seen_nz = seen_nz | (i_value[4*k +: 4] != 4'h0) | (k == 0);
            if (!seen_nz) begin
                seg_byte[6:0] = 7'h00;
            end
`endif
            if (SEG_ACTIVE_LOW != 0) begin
                seg_byte = ~seg_byte;
            end
            frame_d[8*k +: 8] = seg_byte;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
        div_last = (div_q == DIV_LAST);
        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (i_load) begin
                    shift_d = frame_d;
                    bit_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (div_last) begin
                    div_d   = '0;
                    shift_d = shift_q << 1;
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == BIT_LAST) ? ST_LATCH : ST_SETUP;
                end
            end
            ST_LATCH: begin
                if (div_last) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                div_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    assign o_busy                = |state_q;
    assign o_done                = done_q;
    assign o_data_clock          = state_q[1];
    assign o_latch_shifted_value = state_q[2];
    assign o_data_val            = state_q[0] & shift_q[BITS-1];

endmodule

// File: tb/tb_seven_seg_chain_driver.sv
// tb/tb_seven_seg_chain_driver.sv - timeline-model bench for seven_seg_chain_driver in three configurations
module tb_seven_seg_chain_driver;

    localparam logic [7:0] SEG [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [31:0] value_all = '0;
    logic [7:0]  dp_all = '0;
    logic [2:0]  busy_v;
    int          n_vec = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instance 0: 2 digits, div 2. Instance 1: same, active-low. Instance 2: 4 digits, div 1.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int N   = (g == 2) ? 4 : 2;
        localparam int DIV = (g == 2) ? 1 : 2;
        localparam int AL  = (g == 1) ? 1 : 0;
        localparam int B   = 8 * N;

        logic busy, done, dval, dclk, latch;
        logic [63:0] word = '0, last_word = '0, m_word = '0;
        int nbits = 0, bcnt = 0, lcnt = 0, last_bits = 0, last_busy = 0, last_latch = 0;
        int done_cnt = 0, latch_total = 0;
        logic prev_clk = 1'b0;
        logic m_act = 1'b0, m_done = 1'b0;
        int m_j = 0;

        seven_seg_chain_driver #(.NUM_DIGITS(N), .CLK_DIV(DIV), .SEG_ACTIVE_LOW(AL)) dut (
            .i_clk(clk), .i_reset(reset), .i_value(value_all[4*N-1:0]), .i_dp(dp_all[N-1:0]),
            .i_load(load), .o_busy(busy), .o_done(done), .o_data_val(dval),
            .o_data_clock(dclk), .o_latch_shifted_value(latch));

        assign busy_v[g] = busy;

        function automatic logic [63:0] mframe(input logic [31:0] v, input logic [7:0] d);
            int h;
            logic [7:0] b;
            logic [63:0] w;
            h = 0;
            for (int k = 0; k < N; k++) if (v[4*k +: 4] != 4'h0) h = k;
            w = '0;
            for (int k = 0; k < N; k++) begin
                b = SEG[v[4*k +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
                if (k > h) b = 8'h00;
`endif
                b[7] = d[k];
                if (AL != 0) b = ~b;
                w = w | (64'(b) << (8 * k));
            end
            return w;
        endfunction

        initial begin
            int ph;
            logic [4:0] exp;
            @(posedge clk);
            forever begin
                @(negedge clk);
                // Expected outputs from the frame timeline: 2*B half-bit phases then one latch phase.
                if (m_act) begin
                    ph = m_j / DIV;
                    if (ph < 2 * B) exp = {1'b1, 1'b0, m_word[B-1-ph/2], 1'(ph % 2), 1'b0};
                    else            exp = 5'b10001;
                end else begin
                    exp = {1'b0, m_done, 3'b000};
                end
                check($sformatf("u%0d_cycle", g), {busy, done, dval, dclk, latch}, exp);

                if (done) begin
                    last_word = word; last_bits = nbits; last_busy = bcnt; last_latch = lcnt;
                    done_cnt++;
                end
                if (latch) latch_total++;
                if (dclk && !prev_clk) begin
                    word = {word[62:0], dval};
                    nbits++;
                end
                prev_clk = dclk;
                if (busy) begin
                    bcnt++;
                    if (latch) lcnt++;
                end else begin
                    bcnt = 0; lcnt = 0; word = '0; nbits = 0;
                end

                if (reset) begin
                    m_act = 1'b0; m_done = 1'b0;
                end else if (m_act) begin
                    if (m_j == (2 * B + 1) * DIV - 1) begin
                        m_act = 1'b0; m_done = 1'b1;
                    end else begin
                        m_j++;
                    end
                end else begin
                    m_done = 1'b0;
                    if (load) begin
                        m_act = 1'b1; m_j = 0; m_word = mframe(value_all, dp_all);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] v, input logic [7:0] d);
        value_all = v;
        dp_all = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (busy_v == 3'b000) break;
            tick();
        end
        check("idle_wait", 64'(busy_v), 64'h0);
        tick();
        tick();
    endtask

    int d0, l0;

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        check("reset_outs", {g_dut[0].busy, g_dut[0].done, g_dut[0].dval, g_dut[0].dclk, g_dut[0].latch}, 64'h0);

        start(32'h12, 8'h00);
        wait_idle();
        check("t1_u0_word", g_dut[0].last_word, 64'h065B);
        check("t1_u0_busy", g_dut[0].last_busy, 66);
        check("t1_u0_stcp", g_dut[0].last_latch, 2);
        check("t1_u0_bits", g_dut[0].last_bits, 16);
        check("t1_u1_word", g_dut[1].last_word, 64'hF9A4);
        check("t1_u2_busy", g_dut[2].last_busy, 65);
        check("t1_u2_stcp", g_dut[2].last_latch, 1);
        check("t1_u2_bits", g_dut[2].last_bits, 32);
`ifdef LEADING_ZERO_BLANK_EN
        check("t1_u2_word", g_dut[2].last_word, 64'h0000_065B);
`else
        check("t1_u2_word", g_dut[2].last_word, 64'h3F3F_065B);
`endif

        start(32'h12, 8'h01);
        wait_idle();
        check("t2_u1_word", g_dut[1].last_word, 64'hF924);
        check("t2_u0_word", g_dut[0].last_word, 64'h06DB);

        d0 = g_dut[0].done_cnt;
        start(32'h12, 8'h00);
        repeat (9) tick();
        value_all = 32'hAF;
        dp_all = 8'hFF;
        load = 1'b1;
        tick();
        load = 1'b0;
        wait_idle();
        check("t3_ignored_done", g_dut[0].done_cnt - d0, 1);
        check("t3_ignored_word", g_dut[0].last_word, 64'h065B);

        d0 = g_dut[0].done_cnt;
        value_all = 32'h12;
        dp_all = 8'h00;
        load = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (g_dut[0].done) break;
        end
        check("t3_done_seen", 64'(g_dut[0].done), 64'h1);
        tick();
        check("t3_b2b_busy", 64'(g_dut[0].busy), 64'h1);
        load = 1'b0;
        wait_idle();
        check("t3_b2b_frames", g_dut[0].done_cnt - d0, 2);

        d0 = g_dut[0].done_cnt;
        l0 = g_dut[0].latch_total;
        start(32'h12, 8'h00);
        for (int i = 0; i < 200; i++) begin
            if (g_dut[0].nbits == 5) break;
            tick();
        end
        check("t4_shcp5_wait", g_dut[0].nbits, 5);
        reset = 1'b1;
        tick();
        check("t4_reset_outs", {g_dut[0].busy, g_dut[0].done, g_dut[0].dval, g_dut[0].dclk, g_dut[0].latch}, 64'h0);
        reset = 1'b0;
        repeat (150) tick();
        check("t4_no_done", g_dut[0].done_cnt - d0, 0);
        check("t4_no_stcp", g_dut[0].latch_total - l0, 0);
        start(32'hAF, 8'h00);
        wait_idle();
        check("t4_u0_word", g_dut[0].last_word, 64'h7771);
        check("t4_u1_word", g_dut[1].last_word, 64'h888E);

        start(32'h00A0, 8'h00);
        wait_idle();
        check("t5_u0_word", g_dut[0].last_word, 64'h773F);
        check("t5_u2_busy", g_dut[2].last_busy, 65);
`ifdef LEADING_ZERO_BLANK_EN
        check("t5_u2_word", g_dut[2].last_word, 64'h0000_773F);
`else
        check("t5_u2_word", g_dut[2].last_word, 64'h3F3F_773F);
`endif

        start(32'h0000, 8'h00);
        wait_idle();
`ifdef LEADING_ZERO_BLANK_EN
        check("t6_u2_word", g_dut[2].last_word, 64'h0000_003F);
        check("t6_u0_word", g_dut[0].last_word, 64'h003F);
`else
        check("t6_u2_word", g_dut[2].last_word, 64'h3F3F_3F3F);
        check("t6_u0_word", g_dut[0].last_word, 64'h3F3F);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
